// File: rtl/pack_fifo.sv
// pack_fifo: narrow-to-wide sample packer feeding a show-ahead word FIFO.
// RATIO consecutive IN_W-bit samples are packed into one OUT_W word, with a
// flush path that pushes a partially filled word together with a lane-keep
// mask. Occupancy is reported on level; the FIFO head is visible on out_data.
module pack_fifo #(
    parameter int IN_W       = 8,
    parameter int RATIO      = 8,
    parameter int DEPTH      = 16,
    parameter int BYTE_ORDER = 0,
    localparam int OUT_W     = IN_W * RATIO,
    localparam int LW        = $clog2(RATIO),
    localparam int AW        = $clog2(DEPTH),
    localparam int LVW       = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [RATIO-1:0] out_keep,
    output logic [LVW-1:0]   level
);

    localparam logic [LW-1:0]  LAST_LANE = LW'(RATIO - 1);
    localparam logic [LVW-1:0] FULL_LVL  = LVW'(DEPTH);

    // Keep mask for a word holding n samples; lane placement follows BYTE_ORDER.
    function automatic logic [RATIO-1:0] keep_mask(input logic [LW-1:0] n);
        logic [RATIO-1:0] m;
        m = {RATIO{1'b0}};
        for (int i = 0; i < RATIO; i++) begin
            if (i < int'(n)) begin
                if (BYTE_ORDER == 1) begin
                    m[RATIO-1-i] = 1'b1;
                end else begin
                    m[i] = 1'b1;
                end
            end else begin
                m = m;
            end
        end
        return m;
    endfunction

    // Packer state
    logic [LW-1:0]    lane_cnt_r;
    logic [LW-1:0]    lane_cnt_s;
    logic [OUT_W-1:0] pack_r;
    logic [OUT_W-1:0] pack_s;
    logic             flush_pend_r;
    logic             flush_pend_s;

    // FIFO state
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [LVW-1:0]   level_r;
    logic [LVW-1:0]   level_s;
    logic             out_valid_r;
    logic             out_valid_s;
    logic             in_ready_r;
    logic             in_ready_s;
    logic [OUT_W-1:0] mem_data [DEPTH];
    logic [RATIO-1:0] mem_keep [DEPTH];

    // Datapath / control nets
    logic             full_s;
    logic             accept_s;
    logic             complete_s;
    logic             flush_push_s;
    logic             push_s;
    logic             pop_s;
    logic [LW-1:0]    lane_idx_s;
    logic [LW-1:0]    lane_after_s;
    logic [OUT_W-1:0] merged_s;
    logic [OUT_W-1:0] push_data_s;
    logic [RATIO-1:0] push_keep_s;

    // Handshake qualifiers; in_ready_r already encodes the full/flush blocking.
    always_comb begin
        full_s       = (level_r == FULL_LVL);
        accept_s     = in_valid && in_ready_r;
        complete_s   = accept_s && (lane_cnt_r == LAST_LANE);
        flush_push_s = flush_pend_r && !full_s;
        push_s       = complete_s || flush_push_s;
        pop_s        = out_valid_r && out_ready;
        if (BYTE_ORDER == 1) begin
            lane_idx_s = LAST_LANE - lane_cnt_r;
        end else begin
            lane_idx_s = lane_cnt_r;
        end
    end

    // Packer word with the incoming sample dropped into its lane.
    always_comb begin
        merged_s = pack_r;
        for (int i = 0; i < RATIO; i++) begin
            if (LW'(i) == lane_idx_s) begin
                merged_s[i*IN_W +: IN_W] = in_data;
            end else begin
                merged_s[i*IN_W +: IN_W] = pack_r[i*IN_W +: IN_W];
            end
        end
    end

    // Next packer state, push payload and flush-pending bookkeeping.
    always_comb begin
        lane_cnt_s   = lane_cnt_r;
        pack_s       = pack_r;
        flush_pend_s = flush_pend_r;
        push_data_s  = pack_r;
        push_keep_s  = keep_mask(lane_cnt_r);
        lane_after_s = lane_cnt_r;

        if (complete_s) begin
            lane_after_s = {LW{1'b0}};
            lane_cnt_s   = {LW{1'b0}};
            pack_s       = {OUT_W{1'b0}};
            push_data_s  = merged_s;
            push_keep_s  = {RATIO{1'b1}};
        end else if (accept_s) begin
            lane_after_s = lane_cnt_r + LW'(1);
            lane_cnt_s   = lane_cnt_r + LW'(1);
            pack_s       = merged_s;
        end else if (flush_push_s) begin
            lane_cnt_s   = {LW{1'b0}};
            pack_s       = {OUT_W{1'b0}};
            flush_pend_s = 1'b0;
        end else begin
            lane_cnt_s   = lane_cnt_r;
        end

        // A flush only arms if a partial word remains after this cycle's sample.
        if (!flush_pend_r && flush && (lane_after_s != {LW{1'b0}})) begin
            flush_pend_s = 1'b1;
        end else begin
            flush_pend_s = flush_pend_s;
        end
    end

    // Next occupancy and the registered handshake outputs derived from it.
    always_comb begin
        case ({push_s, pop_s})
            2'b10:   level_s = level_r + LVW'(1);
            2'b01:   level_s = level_r - LVW'(1);
            default: level_s = level_r;
        endcase
        out_valid_s = (level_s != {LVW{1'b0}});
        in_ready_s  = !flush_pend_s && !((level_s == FULL_LVL) && (lane_cnt_s == LAST_LANE));
    end

    // Packer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_cnt_r   <= {LW{1'b0}};
            pack_r       <= {OUT_W{1'b0}};
            flush_pend_r <= 1'b0;
        end else begin
            lane_cnt_r   <= lane_cnt_s;
            pack_r       <= pack_s;
            flush_pend_r <= flush_pend_s;
        end
    end

    // FIFO pointers, occupancy and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r    <= {AW{1'b0}};
            rd_ptr_r    <= {AW{1'b0}};
            level_r     <= {LVW{1'b0}};
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            level_r     <= level_s;
            out_valid_r <= out_valid_s;
            in_ready_r  <= in_ready_s;
        end
    end

    // FIFO storage; contents are meaningful only between push and pop.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_data[wr_ptr_r] <= push_data_s;
            mem_keep[wr_ptr_r] <= push_keep_s;
        end
    end

    assign out_data  = mem_data[rd_ptr_r];
    assign out_keep  = mem_keep[rd_ptr_r];
    assign out_valid = out_valid_r;
    assign in_ready  = in_ready_r;
    assign level     = level_r;

endmodule
